// File: rtl/mirror_step_pkg.sv
// =============================================================================
// Module : mirror_step_pkg
// Brief  : Shared FSM encoding, divisor constant and saturation helper for the
//          mirror step generator.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package mirror_step_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Number of step intervals across one full sweep.
  function automatic int div_const(input int points, input int frames);
    return points * frames - 1;
  endfunction

  // True when a zero-extended value does not fit in w bits.
  function automatic logic over_range(input logic [127:0] v, input int w);
    return (v >> w) != 128'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mirror_step_div.sv
// =============================================================================
// Module : mirror_step_div
// Brief  : Radix-2 restoring divider by a constant, one quotient bit per cycle,
//          DATA_W+1 quotient bits, MSB first.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module mirror_step_div #(
  parameter int DATA_W  = 32,
  parameter int DIVISOR = 1799
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              start_i,
  input  logic [DATA_W+1:0] dividend_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic              sat_o
);

  localparam int C_REM_W = $clog2(DIVISOR + 1);
  localparam int C_CNT_W = $clog2(DATA_W + 1);
  localparam logic [C_REM_W-1:0] C_DVS  = C_REM_W'(DIVISOR);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DATA_W);

  logic [C_REM_W-1:0] r_rem;
  logic [DATA_W:0]    r_quo;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_busy;

  logic [C_REM_W:0]   w_shift;
  logic               w_ge;
  logic [C_REM_W-1:0] w_diff;
  logic [DATA_W:0]    w_quo_nxt;

  // r_quo doubles as the dividend shift register; quotient bits enter at the LSB.
  assign w_shift   = {r_rem, r_quo[DATA_W]};
  assign w_ge      = w_shift >= {1'b0, C_DVS};
  assign w_diff    = w_shift[C_REM_W-1:0] - C_DVS;
  assign w_quo_nxt = {r_quo[DATA_W-1:0], w_ge};

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start_i) begin
      // The dividend's extra top bit (rounding carry) is always below the divisor.
      r_rem  <= C_REM_W'(dividend_i[DATA_W+1]);
      r_quo  <= dividend_i[DATA_W:0];
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_ge ? w_diff : w_shift[C_REM_W-1:0];
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == C_LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Result is presented during the final iteration so the caller can capture it at that edge.
  assign busy_o     = r_busy;
  assign done_o     = r_busy & (r_cnt == C_LAST);
  assign quotient_o = w_quo_nxt[DATA_W-1:0];
  assign sat_o      = w_quo_nxt[DATA_W];

endmodule

`default_nettype wire

// File: rtl/mirror_step_gen.sv
// =============================================================================
// Module : mirror_step_gen
// Brief  : Fixed-point mirror step generator: step = 2*thetaM/(P*F-1), then
//          thetaStep_it = it*step with saturation and valid/ready handshakes.
//          Define MIRROR_STEP_ROUND_EN to round the step to nearest.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module mirror_step_gen
  import mirror_step_pkg::*;
#(
  parameter int DATA_W             = 32,
  parameter int IT_W               = 16,
  parameter int POINTS_PER_LINE_P  = 360,
  parameter int NUMBER_OF_FRAMES_P = 5
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              thetaM_valid_i,
  output logic              thetaM_ready_o,
  input  logic [DATA_W-1:0] thetaM_i,
  output logic              step_valid_o,
  output logic [DATA_W-1:0] step_o,
  input  logic              it_valid_i,
  output logic              it_ready_o,
  input  logic [IT_W-1:0]   it_i,
  output logic              thetaStep_it_valid_o,
  input  logic              thetaStep_it_ready_i,
  output logic [DATA_W-1:0] thetaStep_it_o,
  output logic              sat_o
);

  localparam int C_DIV     = div_const(POINTS_PER_LINE_P, NUMBER_OF_FRAMES_P);
  localparam int C_DIVISOR = (C_DIV < 1) ? 1 : C_DIV;
  localparam int C_PROD_W  = IT_W + DATA_W;

  if (POINTS_PER_LINE_P * NUMBER_OF_FRAMES_P < 2) begin : g_bad_div
    $error("mirror_step_gen: POINTS_PER_LINE_P*NUMBER_OF_FRAMES_P must be at least 2");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_step;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_sat;

  logic                w_theta_acc;
  logic                w_it_acc;
  logic [DATA_W+1:0]   w_dividend;
  logic                w_div_busy;
  logic                w_div_done;
  logic                w_div_sat;
  logic [DATA_W-1:0]   w_div_quo;
  logic [C_PROD_W-1:0] w_prod;
  logic                w_prod_sat;

  // A pending result blocks new amplitudes so the step cannot change under it.
  assign thetaM_ready_o = nrst_i & ((r_state == S_IDLE) | (r_state == S_RUN)) & ~r_out_valid;
  assign it_ready_o     = (r_state == S_RUN) & (~r_out_valid | thetaStep_it_ready_i);
  assign w_theta_acc    = thetaM_valid_i & thetaM_ready_o;
  assign w_it_acc       = it_valid_i & it_ready_o;

`ifdef MIRROR_STEP_ROUND_EN
  assign w_dividend = {1'b0, thetaM_i, 1'b0} + (DATA_W + 2)'(C_DIVISOR / 2);
`else
  assign w_dividend = {1'b0, thetaM_i, 1'b0};
`endif

  mirror_step_div #(
    .DATA_W  (DATA_W),
    .DIVISOR (C_DIVISOR)
  ) u_div (
    .clk_i      (clk_i),
    .nrst_i     (nrst_i),
    .start_i    (w_theta_acc),
    .dividend_i (w_dividend),
    .busy_o     (w_div_busy),
    .done_o     (w_div_done),
    .quotient_o (w_div_quo),
    .sat_o      (w_div_sat)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_theta_acc) w_state_nxt = S_DIV;
      S_DIV: begin
        if (w_div_done) begin
          w_state_nxt = S_RUN;
        end else if (!w_div_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN:  if (w_theta_acc) w_state_nxt = S_DIV;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state <= S_IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_DIV) && w_div_done) begin
        r_step <= w_div_sat ? '1 : w_div_quo;
      end
    end
  end

  assign w_prod     = C_PROD_W'(it_i) * C_PROD_W'(r_step);
  assign w_prod_sat = over_range(128'(w_prod), DATA_W);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
    end else if (w_it_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_prod_sat ? '1 : w_prod[DATA_W-1:0];
      r_sat       <= w_prod_sat;
    end else if (thetaStep_it_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign step_valid_o         = (r_state == S_RUN);
  assign step_o               = r_step;
  assign thetaStep_it_valid_o = r_out_valid;
  assign thetaStep_it_o       = r_out_data;
  assign sat_o                = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_mirror_step_gen.sv
// =============================================================================
// Module : tb_mirror_step_gen
// Brief  : Self-checking bench for mirror_step_gen (honours MIRROR_STEP_ROUND_EN).
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_mirror_step_gen;

  localparam int DATA_W = 32;
  localparam int IT_W   = 16;
  localparam int P      = 360;
  localparam int F      = 5;
  localparam int DIV    = P * F - 1;
  localparam int LAT    = DATA_W + 1;   // edges from amplitude accept to step valid

`ifdef MIRROR_STEP_ROUND_EN
  localparam logic [31:0] C_STEP1 = 32'h49;
  localparam logic [31:0] C_STEP2 = 32'h92;
  localparam logic [31:0] C_PROD1 = 32'h000200FF;
`else
  localparam logic [31:0] C_STEP1 = 32'h48;
  localparam logic [31:0] C_STEP2 = 32'h91;
  localparam logic [31:0] C_PROD1 = 32'h0001F9F8;
`endif

  logic              clk_i = 1'b0;
  logic              nrst_i = 1'b0;
  logic              thetaM_valid_i = 1'b0;
  logic              thetaM_ready_o;
  logic [DATA_W-1:0] thetaM_i = '0;
  logic              step_valid_o;
  logic [DATA_W-1:0] step_o;
  logic              it_valid_i = 1'b0;
  logic              it_ready_o;
  logic [IT_W-1:0]   it_i = '0;
  logic              thetaStep_it_valid_o;
  logic              thetaStep_it_ready_i = 1'b1;
  logic [DATA_W-1:0] thetaStep_it_o;
  logic              sat_o;

  always #5 clk_i = ~clk_i;

  mirror_step_gen #(
    .DATA_W             (DATA_W),
    .IT_W               (IT_W),
    .POINTS_PER_LINE_P  (P),
    .NUMBER_OF_FRAMES_P (F)
  ) dut (
    .clk_i                (clk_i),
    .nrst_i               (nrst_i),
    .thetaM_valid_i       (thetaM_valid_i),
    .thetaM_ready_o       (thetaM_ready_o),
    .thetaM_i             (thetaM_i),
    .step_valid_o         (step_valid_o),
    .step_o               (step_o),
    .it_valid_i           (it_valid_i),
    .it_ready_o           (it_ready_o),
    .it_i                 (it_i),
    .thetaStep_it_valid_o (thetaStep_it_valid_o),
    .thetaStep_it_ready_i (thetaStep_it_ready_i),
    .thetaStep_it_o       (thetaStep_it_o),
    .sat_o                (sat_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Step from amplitude by plain arithmetic.
  function automatic logic [31:0] ref_step(input logic [31:0] th);
    logic [63:0] num;
    logic [63:0] q;
    num = {31'b0, th, 1'b0};
`ifdef MIRROR_STEP_ROUND_EN
    num = num + 64'(DIV / 2);
`endif
    q = num / 64'(DIV);
    return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  // Timeline model: a step is pending until a fixed number of edges after its accept.
  logic        m_have = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_step = '0;
  logic [31:0] m_pend_val = '0;
  longint      m_edge = 0;
  longint      m_valid_edge = 0;
  logic        m_ov = 1'b0;
  logic [31:0] m_od = '0;
  logic        m_os = 1'b0;

  logic        m_tready;
  logic        m_iready;
  logic [63:0] m_prod;

  assign m_tready = nrst_i && !m_pend && !m_ov;
  assign m_iready = nrst_i && m_have && !m_pend && (!m_ov || thetaStep_it_ready_i);
  assign m_prod   = {48'b0, it_i} * {32'b0, m_step};

  always @(posedge clk_i) begin
    if (!nrst_i) begin
      m_have <= 1'b0; m_pend <= 1'b0; m_step <= '0; m_pend_val <= '0;
      m_edge <= 0; m_valid_edge <= 0; m_ov <= 1'b0; m_od <= '0; m_os <= 1'b0;
    end else begin
      m_edge <= m_edge + 1;
      if (it_valid_i && m_iready) begin
        m_ov <= 1'b1;
        m_os <= (m_prod > 64'hFFFF_FFFF);
        m_od <= (m_prod > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_prod[31:0];
      end else if (thetaStep_it_ready_i) begin
        m_ov <= 1'b0;
      end
      if (thetaM_valid_i && m_tready) begin
        m_pend       <= 1'b1;
        m_pend_val   <= ref_step(thetaM_i);
        m_valid_edge <= m_edge + 1 + LAT;
      end else if (m_pend && (m_edge + 1 == m_valid_edge)) begin
        m_step <= m_pend_val;
        m_have <= 1'b1;
        m_pend <= 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (!nrst_i) begin
      check("rst_ctl", 64'({thetaM_ready_o, step_valid_o, it_ready_o, thetaStep_it_valid_o, sat_o}), 64'd0);
      check("rst_step", 64'(step_o), 64'd0);
      check("rst_data", 64'(thetaStep_it_o), 64'd0);
    end else begin
      check("thetaM_ready", 64'(thetaM_ready_o), 64'(m_tready));
      check("it_ready", 64'(it_ready_o), 64'(m_iready));
      check("step_valid", 64'(step_valid_o), 64'(m_have && !m_pend));
      check("step", 64'(step_o), 64'(m_step));
      check("out_valid", 64'(thetaStep_it_valid_o), 64'(m_ov));
      if (m_ov) check("out_data", 64'({sat_o, thetaStep_it_o}), 64'({m_os, m_od}));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one amplitude; returns the step_valid/step seen just after accept and edges to valid.
  task automatic send_theta(input logic [31:0] v, output logic drop_sv,
                            output logic [31:0] held, output int lat);
    check("th_ready_before", 64'(thetaM_ready_o), 64'd1);
    thetaM_valid_i = 1'b1;
    thetaM_i       = v;
    tick();
    thetaM_valid_i = 1'b0;
    drop_sv = step_valid_o;
    held    = step_o;
    lat = 0;
    while (!step_valid_o && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        sv;
    logic [31:0] held;
    int          lat;

    repeat (3) tick();
    check("reset_ready", 64'(thetaM_ready_o), 64'd0);
    check("reset_step_valid", 64'(step_valid_o), 64'd0);
    nrst_i = 1'b1;
    tick();
    check("idle_ready", 64'(thetaM_ready_o), 64'd1);

    send_theta(32'h0001_0000, sv, held, lat);
    check("first_drop", 64'(sv), 64'd0);
    check("first_latency", 64'(lat), 64'd33);
    check("first_step", 64'(step_o), 64'(C_STEP1));

    it_valid_i = 1'b1;
    it_i       = 16'd1799;
    tick();
    it_valid_i = 1'b0;
    check("it1799_valid", 64'(thetaStep_it_valid_o), 64'd1);
    check("it1799_data", 64'({sat_o, thetaStep_it_o}), 64'({1'b0, C_PROD1}));
    tick();

    // Backpressure: one result held while the next iteration waits.
    thetaStep_it_ready_i = 1'b0;
    it_valid_i = 1'b1;
    it_i       = 16'd3;
    tick();
    it_i = 16'd5;
    for (int k = 0; k < 5; k++) begin
      check("bp_it_ready", 64'(it_ready_o), 64'd0);
      check("bp_hold", 64'({thetaStep_it_valid_o, thetaStep_it_o}), 64'({1'b1, 3 * C_STEP1}));
      tick();
    end
    thetaStep_it_ready_i = 1'b1;
    tick();
    it_valid_i = 1'b0;
    check("bp_next", 64'({thetaStep_it_valid_o, thetaStep_it_o}), 64'({1'b1, 5 * C_STEP1}));
    tick();
    check("bp_drained", 64'(thetaStep_it_valid_o), 64'd0);

    it_valid_i = 1'b1;
    it_i       = 16'd0;
    tick();
    it_valid_i = 1'b0;
    check("it_zero", 64'({thetaStep_it_valid_o, sat_o, thetaStep_it_o}), 64'({2'b10, 32'd0}));
    tick();

    send_theta(32'h0002_0000, sv, held, lat);
    check("run_drop", 64'(sv), 64'd0);
    check("run_held_step", 64'(held), 64'(C_STEP1));
    check("run_latency", 64'(lat), 64'd33);
    check("run_step", 64'(step_o), 64'(C_STEP2));

    for (int c = 0; c < 3000; c++) begin
      thetaM_valid_i = ($urandom_range(0, 99) < 3);
      thetaM_i       = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 32'h0010_0000) : $urandom;
      it_valid_i     = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 3))
        0:       it_i = 16'd0;
        1:       it_i = 16'(DIV);
        2:       it_i = 16'hFFFF;
        default: it_i = 16'($urandom);
      endcase
      thetaStep_it_ready_i = ($urandom_range(0, 99) < 75);
      tick();
    end
    thetaM_valid_i = 1'b0;
    it_valid_i     = 1'b0;
    thetaStep_it_ready_i = 1'b1;
    repeat (40) tick();

    send_theta(32'hFFFF_FFFF, sv, held, lat);
    check("max_latency", 64'(lat), 64'd33);
    it_valid_i = 1'b1;
    it_i       = 16'hFFFF;
    tick();
    it_valid_i = 1'b0;
    check("sat_result", 64'({thetaStep_it_valid_o, sat_o, thetaStep_it_o}), 64'({2'b11, 32'hFFFF_FFFF}));
    tick();

    // Reset ten cycles into a division.
    thetaM_valid_i = 1'b1;
    thetaM_i       = 32'h0003_0000;
    tick();
    thetaM_valid_i = 1'b0;
    repeat (10) tick();
    nrst_i = 1'b0;
    #1;
    check("midrst_ctl", 64'({thetaM_ready_o, step_valid_o, it_ready_o, thetaStep_it_valid_o, sat_o}), 64'd0);
    check("midrst_step", 64'(step_o), 64'd0);
    tick();
    tick();
    nrst_i = 1'b1;
    tick();
    send_theta(32'h0001_0000, sv, held, lat);
    check("after_rst_latency", 64'(lat), 64'd33);
    check("after_rst_step", 64'(step_o), 64'(C_STEP1));
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
